// File: rtl/pulse_train_if.sv
// Interface bundling the control, configuration and status signals of the
// pulse train generator. The master side requests bursts; the slave side
// (the generator) produces the waveform and status.
interface pulse_train_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] burst_len;
  logic             clk_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start,
    output stop,
    output high_len,
    output low_len,
    output burst_len,
    input  clk_out,
    input  busy,
    input  done,
    input  pulse_cnt
  );

  modport slave (
    input  start,
    input  stop,
    input  high_len,
    input  low_len,
    input  burst_len,
    output clk_out,
    output busy,
    output done,
    output pulse_cnt
  );

endinterface

// File: rtl/pulse_train_gen.sv
// Programmable square-wave burst generator. Every low phase is at least
// MIN_LOW cycles and every high phase at least MIN_HIGH cycles so the
// downstream edge-detecting divider always sees a clean, debounced edge.
// The burst ends with a full-length trailing low before returning to idle.
module pulse_train_gen #(
  parameter int CNT_W    = 16,
  parameter int MIN_LOW  = 9,
  parameter int MIN_HIGH = 4
) (
  input  logic          clk_inner,
  input  logic          rst_n,
  pulse_train_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LOW_V  = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] MIN_HIGH_V = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] len_cnt, len_nx;
  logic [CNT_W-1:0] eff_high, eff_high_nx;
  logic [CNT_W-1:0] eff_low, eff_low_nx;
  logic [CNT_W-1:0] burst_lat, burst_nx;
  logic [CNT_W-1:0] pulse_cnt, pulse_nx;
  logic             stop_lat, stop_nx;
  logic             clk_out, clk_out_nx;
  logic             busy, busy_nx;
  logic             done, done_nx;

  logic [CNT_W-1:0] eff_high_in;
  logic [CNT_W-1:0] eff_low_in;
  logic             stop_seen;
  logic             burst_reached;

  assign eff_high_in   = (bus.high_len < MIN_HIGH_V) ? MIN_HIGH_V : bus.high_len;
  assign eff_low_in    = (bus.low_len  < MIN_LOW_V)  ? MIN_LOW_V  : bus.low_len;
  assign stop_seen     = stop_lat | bus.stop;
  assign burst_reached = (burst_lat != '0) && (pulse_cnt == burst_lat);

  // State, counters and registered outputs; reset forces clk_out low at once
  always_ff @(posedge clk_inner or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_cnt   <= '0;
      eff_high  <= '0;
      eff_low   <= '0;
      burst_lat <= '0;
      pulse_cnt <= '0;
      stop_lat  <= 1'b0;
      clk_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      len_cnt   <= len_nx;
      eff_high  <= eff_high_nx;
      eff_low   <= eff_low_nx;
      burst_lat <= burst_nx;
      pulse_cnt <= pulse_nx;
      stop_lat  <= stop_nx;
      clk_out   <= clk_out_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Next-state logic; len_cnt holds the remaining cycles of the phase minus one
  always_comb begin
    state_nx    = state;
    len_nx      = len_cnt;
    eff_high_nx = eff_high;
    eff_low_nx  = eff_low;
    burst_nx    = burst_lat;
    pulse_nx    = pulse_cnt;
    stop_nx     = stop_lat;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          eff_high_nx = eff_high_in;
          eff_low_nx  = eff_low_in;
          burst_nx    = bus.burst_len;
          pulse_nx    = '0;
          len_nx      = eff_low_in - ONE;
          stop_nx     = 1'b0;
          state_nx    = LOW;
        end
      end

      LOW: begin
        stop_nx = stop_seen;
        if (len_cnt == '0) begin
          if (stop_seen) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            stop_nx  = 1'b0;
          end else begin
            state_nx = HIGH;
            len_nx   = eff_high - ONE;
            pulse_nx = pulse_cnt + ONE;
          end
        end else begin
          len_nx = len_cnt - ONE;
          if (stop_seen) begin
            state_nx = TAIL;
          end
        end
      end

      HIGH: begin
        stop_nx = stop_seen;
        if (len_cnt == '0) begin
          len_nx = eff_low - ONE;
          if (stop_seen || burst_reached) begin
            state_nx = TAIL;
          end else begin
            state_nx = LOW;
          end
        end else begin
          len_nx = len_cnt - ONE;
        end
      end

      TAIL: begin
        if (len_cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          stop_nx  = 1'b0;
        end else begin
          len_nx = len_cnt - ONE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    clk_out_nx = (state_nx == HIGH);
    busy_nx    = (state_nx != IDLE);
  end

  assign bus.clk_out   = clk_out;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pulse_cnt = pulse_cnt;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Generates a clean, programmable square-wave burst on a single output for the lab's edge-detecting frequency divider.
- Every high phase and every low phase is long enough to pass the divider's debounce pattern, which needs at least 9 consecutive low samples followed by at least 4 high samples.
- Used as an on-chip stimulus source. clk_out is wired to the divider's clk_cnt input, and both blocks run on clk_inner.

Parameters:
- CNT_W, 16, width of the length, burst and pulse-count fields.
- MIN_LOW, 9, minimum low-phase length in clk_inner cycles.
- MIN_HIGH, 4, minimum high-phase length in clk_inner cycles.

Ports:
- clk_inner  in   1      system clock; all logic is on the rising edge.
- rst_n      in   1      asynchronous active-low reset.
- start      in   1      one-cycle request to begin a burst.
- stop       in   1      request to end the burst early; level or pulse.
- high_len   in   CNT_W  requested high-phase length in cycles.
- low_len    in   CNT_W  requested low-phase length in cycles.
- burst_len  in   CNT_W  number of pulses; 0 means continuous.
- clk_out    out  1      generated waveform, registered.
- busy       out  1      high from the first LOW cycle until done.
- done       out  1      one-cycle pulse when the burst ends.
- pulse_cnt  out  CNT_W  rising edges emitted in the current or last burst.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; clk_out=0, busy=0, done=0, pulse_cnt=0; internal counters=0.
- States: IDLE, LOW, HIGH, TAIL.
- IDLE:
  - start=1 and stop=0 sampled at edge t:
    - latch eff_high = max(high_len, MIN_HIGH) and eff_low = max(low_len, MIN_LOW);
    - latch burst_len;
    - clear pulse_cnt;
    - go to LOW.
  - start and stop together in IDLE: the request is ignored.
- LOW:
  - clk_out=0 for exactly eff_low cycles, starting at t+1.
  - Then go to HIGH and increment pulse_cnt in the same edge as clk_out rises.
- HIGH:
  - clk_out=1 for exactly eff_high cycles.
  - At the end, go to TAIL if either condition holds:
    - burst_len≠0 and pulse_cnt==burst_len;
    - a stop request is latched.
  - Otherwise go to LOW.
- TAIL:
  - clk_out=0 for eff_low cycles, so the last pulse has a proper trailing low.
  - Then go to IDLE. done=1 for one cycle coinciding with the first IDLE cycle; busy=0 in that same cycle.
- stop handling:
  - stop is latched (sticky) while busy.
  - In LOW: the current LOW completes, no further pulse is started, and the block goes directly to TAIL semantics. The remaining LOW cycles count as the tail, so the total low is eff_low.
  - In HIGH: the HIGH completes, then TAIL.
  - In TAIL: no effect.
  - The sticky latch clears on entering IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - Config inputs are sampled only at start; changing them mid-burst has no effect.
- Timing:
  - clk_out is a flop output and is glitch-free.
  - Period = eff_high + eff_low.
  - First rising edge appears at t+eff_low+1.
- Width rules:
  - Length counters are CNT_W wide; a length of 2^CNT_W−1 is legal.
  - In continuous mode pulse_cnt wraps modulo 2^CNT_W and never terminates the burst.
- busy is 1 in LOW, HIGH and TAIL; 0 in IDLE.
- Reset mid-burst: everything returns immediately to reset values, clk_out drops to 0 asynchronously, and no done pulse is produced.

Test Plan:
1. Nominal burst.
   - Stimulus: high_len=4, low_len=9, burst_len=3, start pulse.
   - Required response:
     - clk_out shows low 9 / high 4 ×3, then a 9-cycle tail;
     - pulse_cnt=3;
     - done pulses once at cycle 1+3·13+9;
     - the divider fed by clk_out toggles Cout exactly 3 times.
2. Clamping.
   - Stimulus: high_len=1, low_len=0, burst_len=2.
   - Required response: waveform is identical to high=4, low=9; period 13.
3. Continuous mode with early stop.
   - Stimulus: burst_len=0, high_len=10, low_len=20; assert stop in cycle 5 of the 3rd HIGH.
   - Required response: that HIGH completes 10 cycles, a 20-cycle tail follows, then done; pulse_cnt=3.
4. Stop during LOW.
   - Stimulus: stop in the 2nd LOW.
   - Required response: no 2nd rising edge; done after that LOW completes; pulse_cnt=1.
5. Ignored requests.
   - Stimulus: start during a burst, and start together with stop in IDLE.
   - Required response:
     - the running burst is unchanged, with no restart;
     - the IDLE start+stop gives busy=0 with no waveform.
6. Reset mid-burst.
   - Stimulus: rst_n=0 during HIGH.
   - Required response:
     - clk_out=0, busy=0, pulse_cnt=0 immediately;
     - no done pulse;
     - a fresh start after release runs normally.
